// File: rtl/vnlp_norm_finish_pkg.sv
// Shared constants and state encoding for the norm finishing stage.
// The magnitude width is derived from the squared-norm width.
package vnlp_norm_finish_pkg;
  localparam int precis     = 39;
  localparam int len_size   = 8;
  localparam int mag_size   = (precis + 1) / 2;
  localparam int state_size = 2;
  localparam int DIV_ITERS  = precis;
  localparam int SQRT_ITERS = mag_size;
  localparam int CNT_W      = 6;

  typedef enum logic [state_size-1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SQRT = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/vnlp_norm_finish_div.sv
// Restoring divider: one quotient bit per step, MSB first.
// Dividend and quotient share one shift register.
module seq_divider #(
  parameter int DATA_W = 39,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DIV_W-1:0]  divisor,
  output logic [DATA_W-1:0] quotient
);
  logic [DATA_W-1:0] dq_p0;
  logic [DIV_W:0]    rem_p0;
  logic [DIV_W-1:0]  dvs_p0;
  logic [DIV_W:0]    shifted;
  logic [DIV_W:0]    diff;
  logic              fits;

  always_comb begin
    shifted = (rem_p0 << 1) | (DIV_W+1)'(dq_p0[DATA_W-1]);
    diff    = shifted - {1'b0, dvs_p0};
    fits    = (shifted >= {1'b0, dvs_p0});
  end

  // partial remainder stays below the divisor, so DIV_W+1 bits never overflow
  always_ff @(posedge clk) begin
    if (load) begin
      dq_p0  <= dividend;
      rem_p0 <= '0;
      dvs_p0 <= divisor;
    end else if (step) begin
      dq_p0  <= (dq_p0 << 1) | DATA_W'(fits);
      rem_p0 <= fits ? diff : shifted;
    end
  end

  assign quotient = dq_p0;
endmodule

// File: rtl/vnlp_norm_finish.sv
// Finishing stage: floor(sqrt(norm2)) and floor(norm2/len) computed
// bit-serially after a level-sensitive, edge-armed acceptance.
module vnlp_norm_finish
  import vnlp_norm_finish_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [precis-1:0]     norm2,
  input  logic [len_size-1:0]   len,
  output logic [mag_size-1:0]   mag,
  output logic [precis-1:0]     mean_sq,
  output logic                  div_err,
  output logic                  out_valid,
  output logic                  busy,
  output logic [state_size-1:0] the_state
);
  state_t                state, state_nxt;
  logic                  armed;
  logic                  accept;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_last;
  logic                  finish;
  logic                  len_zero_p0;
  logic [precis-1:0]     quotient;
  logic [2*mag_size-1:0] sq_op_p0;
  logic [mag_size-1:0]   root_p0, root_nxt;
  logic [mag_size+1:0]   sq_rem_p0, sq_rem_t, sq_trial, rem_nxt;
  logic                  sq_fits;

  assign accept   = (state == IDLE) && armed && in_valid;
  assign cnt_last = (cnt == '0);
  assign finish   = (state == SQRT) && cnt_last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DIV;
      DIV:     if (cnt_last) state_nxt = SQRT;
      SQRT:    if (cnt_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) armed <= 1'b0;
      else if (!in_valid) armed <= 1'b1;
      // the shared iteration counter reloads on every state entry
      if (state_nxt != state) begin
        case (state_nxt)
          DIV:     cnt <= CNT_W'(DIV_ITERS - 1);
          SQRT:    cnt <= CNT_W'(SQRT_ITERS - 1);
          default: cnt <= '0;
        endcase
      end else if (!cnt_last) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  seq_divider #(
    .DATA_W(precis),
    .DIV_W (len_size)
  ) u_div (
    .clk      (clk),
    .load     (accept),
    .step     (state == DIV),
    .dividend (norm2),
    .divisor  (len),
    .quotient (quotient)
  );

  // digit-by-digit root: bring down two operand bits, try (root<<2)|1
  always_comb begin
    sq_rem_t = (sq_rem_p0 << 2) | (mag_size+2)'(sq_op_p0[2*mag_size-1 -: 2]);
    sq_trial = {root_p0, 2'b01};
    sq_fits  = (sq_rem_t >= sq_trial);
    rem_nxt  = sq_fits ? (sq_rem_t - sq_trial) : sq_rem_t;
    root_nxt = (root_p0 << 1) | mag_size'(sq_fits);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      len_zero_p0 <= (len == '0);
      sq_op_p0    <= (2*mag_size)'(norm2);
      root_p0     <= '0;
      sq_rem_p0   <= '0;
    end else if (state == SQRT) begin
      sq_op_p0    <= sq_op_p0 << 2;
      root_p0     <= root_nxt;
      sq_rem_p0   <= rem_nxt;
    end
  end

  // results land on the edge entering DONE so they are visible with out_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag       <= '0;
      mean_sq   <= '0;
      div_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= finish;
      if (finish) begin
        mag     <= root_nxt;
        mean_sq <= len_zero_p0 ? '0 : quotient;
        div_err <= len_zero_p0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign the_state = state;
endmodule
